// File: rtl/addr_seq_pkg.sv
// Shared types for the register address sequencer: state encoding and width.
package addr_seq_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    DATA      = 2'd2
  } seq_state_t;

endpackage

// File: rtl/address_increment.sv
// Combinational next-address function for the register pointer.
// Define ADDR_PAGE_WRAP_EN to wrap within a 2^PAGE_BITS page instead of at REG_COUNT.
module address_increment #(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_COUNT  = 32,
  parameter int PAGE_BITS  = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  // One extra bit so neither the +1 nor the limit compare can overflow.
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);

  logic [ADDR_WIDTH:0] addr_ext;
  assign addr_ext = {1'b0, addr};

`ifdef ADDR_PAGE_WRAP_EN
  localparam logic [ADDR_WIDTH:0] LOW_MASK = (ADDR_WIDTH+1)'((1 << PAGE_BITS) - 1);

  logic [ADDR_WIDTH:0] low_sum;
  logic [ADDR_WIDTH:0] page_base;
  logic [ADDR_WIDTH:0] candidate;
  logic                low_wrap;

  always_comb begin
    low_sum   = (addr_ext & LOW_MASK) + (ADDR_WIDTH+1)'(1);
    low_wrap  = |(low_sum & ~LOW_MASK);
    page_base = addr_ext & ~LOW_MASK;
    candidate = page_base | (low_sum & LOW_MASK);
    if (low_wrap || (candidate >= REG_LIMIT)) begin
      next_addr = page_base[ADDR_WIDTH-1:0];
    end else begin
      next_addr = candidate[ADDR_WIDTH-1:0];
    end
  end
`else
  logic [ADDR_WIDTH:0] sum;

  always_comb begin
    sum = addr_ext + (ADDR_WIDTH+1)'(1);
    if (sum >= REG_LIMIT) begin
      next_addr = '0;
    end else begin
      next_addr = sum[ADDR_WIDTH-1:0];
    end
  end
`endif

endmodule

// File: rtl/address_sequencer.sv
// Auto-incrementing register address pointer driven by bus start/stop/byte strobes.
// Wrap behaviour selected by ADDR_PAGE_WRAP_EN (see address_increment).
module address_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_COUNT  = 32,
  parameter int PAGE_BITS  = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   RW,
  input  logic                   BYTE_VALID,
  input  logic [7:0]             BYTE_DATA,
  output logic [ADDR_WIDTH-1:0]  ADDR_BUS,
  output logic                   ADDR_VALID,
  output logic                   ADDR_ERR,
  output logic [STATE_WIDTH-1:0] STATE
);

  localparam logic [8:0] BYTE_LIMIT = 9'(REG_COUNT);

  seq_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  err_reg, err_next;
  logic                  valid_reg;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  byte_in_range;

  address_increment #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .PAGE_BITS  (PAGE_BITS)
  ) u_increment (
    .addr      (addr_reg),
    .next_addr (addr_inc)
  );

  assign byte_in_range = ({1'b0, BYTE_DATA} < BYTE_LIMIT);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    err_next   = 1'b0;
    if (START) begin
      // Repeated start re-evaluates direction and drops any same-cycle byte.
      state_next = RW ? DATA : WAIT_ADDR;
    end else begin
      if (BYTE_VALID) begin
        case (state_reg)
          WAIT_ADDR: begin
            if (byte_in_range) begin
              addr_next = BYTE_DATA[ADDR_WIDTH-1:0];
            end else begin
              addr_next = '0;
              err_next  = 1'b1;
            end
            state_next = DATA;
          end
          DATA:    addr_next = addr_inc;
          default: ;
        endcase
      end
      // STOP wins the state but keeps the pointer effect of a same-cycle byte.
      if (STOP) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
      valid_reg <= (state_next == DATA);
    end
  end

  assign ADDR_BUS   = addr_reg;
  assign ADDR_VALID = valid_reg;
  assign ADDR_ERR   = err_reg;
  assign STATE      = state_reg;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed self-checking bench for address_sequencer (ADDR_WIDTH=8, REG_COUNT=32, PAGE_BITS=3).
module tb_address_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       rw = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic [7:0] addr_bus;
  logic       addr_valid;
  logic       addr_err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  address_sequencer #(
    .ADDR_WIDTH (8),
    .REG_COUNT  (32),
    .PAGE_BITS  (3)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .STOP       (stop),
    .RW         (rw),
    .BYTE_VALID (byte_valid),
    .BYTE_DATA  (byte_data),
    .ADDR_BUS   (addr_bus),
    .ADDR_VALID (addr_valid),
    .ADDR_ERR   (addr_err),
    .STATE      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Apply one cycle of strobes, let the edge pass, then release them.
  task automatic drive(input logic s, input logic d, input logic p,
                       input logic bv, input logic [7:0] data);
    start = s; rw = d; stop = p; byte_valid = bv; byte_data = data;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (addr_bus !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", addr_bus); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", addr_valid); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", addr_err); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    $display("txn reset: addr=%h valid=%b state=%0d", addr_bus, addr_valid, state);
  endtask

  task automatic test_burst_write();
    logic [7:0] exp_addr;
    drive(1, 0, 0, 0, 8'h00);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL burst_wait_state got %0d want 1", state); end
    drive(0, 0, 0, 1, 8'h05);
    checks++; if (addr_bus !== 8'h05) begin errors++; $display("FAIL burst_load got %h want 05", addr_bus); end
    checks++; if (addr_valid !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL burst_data_state got valid=%b state=%0d want 1/2", addr_valid, state); end
    exp_addr = 8'h05;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 8'hA0 + 8'(i));
      exp_addr = exp_addr + 8'h01;
      checks++; if (addr_bus !== exp_addr || addr_valid !== 1'b1) begin errors++; $display("FAIL burst_inc%0d got %h/%b want %h/1", i, addr_bus, addr_valid, exp_addr); end
      $display("txn burst byte %0d: addr=%h", i, addr_bus);
    end
    drive(0, 0, 1, 0, 8'h00);
    checks++; if (state !== 2'd0 || addr_bus !== 8'h08 || addr_valid !== 1'b0) begin errors++; $display("FAIL burst_stop got state=%0d addr=%h valid=%b want 0/08/0", state, addr_bus, addr_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_wrap;
`ifdef ADDR_PAGE_WRAP_EN
    exp_wrap = 8'h18;
`else
    exp_wrap = 8'h00;
`endif
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h1F);
    checks++; if (addr_bus !== 8'h1F || addr_err !== 1'b0) begin errors++; $display("FAIL wrap_load got %h err=%b want 1f/0", addr_bus, addr_err); end
    drive(0, 0, 0, 1, 8'h55);
    checks++; if (addr_bus !== exp_wrap) begin errors++; $display("FAIL wrap_next got %h want %h", addr_bus, exp_wrap); end
    $display("txn wrap: addr=%h", addr_bus);
    drive(0, 0, 1, 0, 8'h00);
  endtask

  task automatic test_out_of_range();
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h40);
    checks++; if (addr_err !== 1'b1 || addr_bus !== 8'h00 || state !== 2'd2) begin errors++; $display("FAIL oor_err got err=%b addr=%h state=%0d want 1/00/2", addr_err, addr_bus, state); end
    drive(0, 0, 0, 0, 8'h00);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_pulse got %b want 0", addr_err); end
    // First illegal value sits exactly at REG_COUNT.
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h20);
    checks++; if (addr_err !== 1'b1 || addr_bus !== 8'h00) begin errors++; $display("FAIL oor_boundary got err=%b addr=%h want 1/00", addr_err, addr_bus); end
    $display("txn out_of_range: addr=%h err=%b", addr_bus, addr_err);
    drive(0, 0, 1, 0, 8'h00);
  endtask

  task automatic test_read_after_addr();
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h0A);
    drive(0, 0, 1, 0, 8'h00);
    checks++; if (addr_bus !== 8'h0A || state !== 2'd0) begin errors++; $display("FAIL rd_addr_set got %h state=%0d want 0a/0", addr_bus, state); end
    drive(1, 1, 0, 0, 8'h00);
    checks++; if (addr_bus !== 8'h0A || state !== 2'd2 || addr_valid !== 1'b1) begin errors++; $display("FAIL rd_start got %h state=%0d valid=%b want 0a/2/1", addr_bus, state, addr_valid); end
    drive(0, 0, 0, 1, 8'h00);
    checks++; if (addr_bus !== 8'h0B) begin errors++; $display("FAIL rd_byte1 got %h want 0b", addr_bus); end
    drive(0, 0, 0, 1, 8'h00);
    checks++; if (addr_bus !== 8'h0C) begin errors++; $display("FAIL rd_byte2 got %h want 0c", addr_bus); end
    drive(1, 1, 0, 1, 8'h00);
    checks++; if (addr_bus !== 8'h0C || state !== 2'd2) begin errors++; $display("FAIL rd_start_drop got %h state=%0d want 0c/2", addr_bus, state); end
    drive(1, 0, 0, 1, 8'h03);
    checks++; if (addr_bus !== 8'h0C || state !== 2'd1) begin errors++; $display("FAIL rd_restart_wr got %h state=%0d want 0c/1", addr_bus, state); end
    $display("txn read_after_addr: addr=%h state=%0d", addr_bus, state);
    drive(0, 0, 1, 0, 8'h00);
  endtask

  task automatic test_stop_edges();
    // STOP in WAIT_ADDR without a byte leaves the pointer alone.
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    checks++; if (state !== 2'd0 || addr_bus !== 8'h0C || addr_err !== 1'b0) begin errors++; $display("FAIL stop_wait got state=%0d addr=%h err=%b want 0/0c/0", state, addr_bus, addr_err); end
    drive(0, 0, 0, 1, 8'h11);
    checks++; if (addr_bus !== 8'h0C || state !== 2'd0) begin errors++; $display("FAIL idle_byte got %h state=%0d want 0c/0", addr_bus, state); end
    drive(1, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h00);
    checks++; if (addr_bus !== 8'h0D || state !== 2'd0 || addr_valid !== 1'b0) begin errors++; $display("FAIL stop_with_byte got %h state=%0d valid=%b want 0d/0/0", addr_bus, state, addr_valid); end
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h07);
    checks++; if (addr_bus !== 8'h07 || state !== 2'd0) begin errors++; $display("FAIL stop_with_addr got %h state=%0d want 07/0", addr_bus, state); end
    $display("txn stop_edges: addr=%h state=%0d", addr_bus, state);
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h12);
    checks++; if (addr_bus !== 8'h12 || state !== 2'd2) begin errors++; $display("FAIL midrst_setup got %h state=%0d want 12/2", addr_bus, state); end
    rst = 1'b1;
    drive(0, 0, 0, 1, 8'h00);
    rst = 1'b0;
    checks++; if (addr_bus !== 8'h00 || state !== 2'd0 || addr_valid !== 1'b0) begin errors++; $display("FAIL midrst got %h state=%0d valid=%b want 00/0/0", addr_bus, state, addr_valid); end
    $display("txn mid_reset: addr=%h state=%0d", addr_bus, state);
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_wrap();
    test_out_of_range();
    test_read_after_addr();
    test_stop_edges();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Parametrised, auto-incrementing register address pointer for the PWM IO expander's serial register interface. It sits between the bus byte engine (start/stop/byte strobes) and the register file. It captures the first byte of a write transaction as the register address. It then advances the pointer after every transferred data byte, so multi-byte bursts reach consecutive PWM/IO registers. The pointer is retained across transactions, so a read issued after an address-only write starts at that address.

## Interface
- ADDR_WIDTH, default 8: pointer width in bits (1..8); the address is taken from BYTE_DATA[ADDR_WIDTH-1:0].
- REG_COUNT, default 32: number of implemented registers. Legal addresses are 0..REG_COUNT-1, and REG_COUNT ≤ 2^ADDR_WIDTH.
- PAGE_BITS, default 3: page size is 2^PAGE_BITS. Used only with ADDR_PAGE_WRAP_EN.
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  one-cycle pulse; bus (repeated) start, with direction valid on RW.
- STOP  in  1  one-cycle pulse; bus stop.
- RW  in  1  direction, sampled only with START (1 = read, 0 = write).
- BYTE_VALID  in  1  one-cycle pulse; a byte completed transfer.
- BYTE_DATA  in  8  received byte, valid with BYTE_VALID.
- ADDR_BUS  out  ADDR_WIDTH  current register address, registered.
- ADDR_VALID  out  1  high while in DATA state.
- ADDR_ERR  out  1  one-cycle pulse on an out-of-range address byte.
- STATE  out  2  state code for debug: IDLE=0, WAIT_ADDR=1, DATA=2.

## Operation
- States are IDLE, WAIT_ADDR and DATA.
- Input priority per cycle: RST > START > BYTE_VALID. STOP is evaluated together with BYTE_VALID.
- **IDLE**
  - BYTE_VALID is ignored.
  - START with RW=0 goes to WAIT_ADDR.
  - START with RW=1 goes to DATA, with the pointer unchanged.
- **WAIT_ADDR**, on BYTE_VALID:
  - If the byte value b < REG_COUNT, ADDR_BUS <= b.
  - Otherwise, ADDR_BUS <= 0 and ADDR_ERR pulses.
  - Either way, go to DATA.
- **DATA**
  - The register file uses ADDR_BUS during the byte. On BYTE_VALID, ADDR_BUS <= next(ADDR_BUS).
  - The same rule applies to read and write transfers.
- **next(a), without the macro:** a+1, or 0 when a = REG_COUNT-1.
- **START in any non-IDLE state (repeated start):**
  - The direction is re-evaluated: RW=0 goes to WAIT_ADDR, RW=1 goes to DATA.
  - The pointer is held.
  - A BYTE_VALID in the same cycle is dropped.
- **STOP in any state:** go to IDLE, pointer retained. If BYTE_VALID arrives in the same cycle, its pointer effect (load or increment) is applied first.
- **STOP in WAIT_ADDR with no byte:** go to IDLE, pointer unchanged, no error.
- **Arithmetic:** increment is done at ADDR_WIDTH+1 bits, so no silent overflow. The comparison against REG_COUNT is unsigned.

## Timing
- **Reset values:** ADDR_BUS=0, ADDR_VALID=0, ADDR_ERR=0, STATE=IDLE.
- **RST mid-operation:** takes effect at the next edge and overrides all same-cycle strobes.
- **Latency:** one cycle for all events.
  - An address load or increment is visible on ADDR_BUS in the cycle after BYTE_VALID.
  - The ADDR_ERR pulse is asserted in the same cycle ADDR_BUS shows 0.
- **ADDR_VALID:** rises the cycle after the transition to DATA and falls the cycle after STOP.
- **Strobe spacing:** back-to-back BYTE_VALID on consecutive cycles is supported, one increment per strobe.
- **Outputs:** all outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **Macro ADDR_PAGE_WRAP_EN**
  - **Defined (page wrap):** next(a) keeps a[ADDR_WIDTH-1:PAGE_BITS] and increments only the low PAGE_BITS bits. If the low bits overflow, or the result is ≥ REG_COUNT, next(a) is the page base a & ~(2^PAGE_BITS-1).
  - **Undefined (linear wrap):** next(a) uses the linear wrap rule at REG_COUNT-1 → 0; PAGE_BITS is unused.

## Structure
- **Shared package addr_seq_pkg:**
  - state enum: IDLE, WAIT_ADDR, DATA, with the 2-bit codes listed above;
  - the state-width constant.
- **Sub-module address_increment:** purely combinational next(a) with both wrap rules behind the macro. It is instantiated once. The state machine and pointer register live in address_sequencer.

## Test plan
All scenarios use ADDR_WIDTH=8, REG_COUNT=32, PAGE_BITS=3.
- **Reset:** assert RST for 2 cycles → ADDR_BUS=0x00, ADDR_VALID=0, ADDR_ERR=0, STATE=0.
- **Burst write:** START(RW=0), byte 0x05, then 3 data bytes → ADDR_BUS 0x05, 0x06, 0x07, 0x08; ADDR_VALID=1 throughout; STOP → STATE=0, ADDR_BUS stays 0x08.
- **Wrap:** load 0x1F, then 1 data byte → 0x00 without the macro; 0x18 with ADDR_PAGE_WRAP_EN defined.
- **Out-of-range:** START(RW=0), byte 0x40 → one-cycle ADDR_ERR, ADDR_BUS=0x00, STATE=DATA.
- **Read after address set:** write address 0x0A, STOP, START(RW=1), 2 bytes → ADDR_BUS 0x0A, 0x0B, 0x0C; START with BYTE_VALID in the same cycle → byte dropped.
- **Mid-burst reset:** at ADDR_BUS=0x12 in DATA, RST together with BYTE_VALID → next cycle ADDR_BUS=0x00, STATE=IDLE, ADDR_VALID=0.
